// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared state encodings, defaults and index-width helper for the UART TX arbiter
package uart_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam int DEF_DATA_BITS = 8;
  localparam logic [DEF_DATA_BITS-1:0] IDLE_BYTE = '1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: client request/data bus plus transmitter handshake
//   master (arbiter): in req, lock, w_data, tx_done_tick; out ack, busy, grant_id, tx_start, d_in, timeout_err
//   slave (clients/transmitter): the mirror image
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N_CLIENTS = 4,
  parameter int DATA_BITS = DEF_DATA_BITS
) ();
  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] lock;
  logic [N_CLIENTS*DATA_BITS-1:0] w_data;
  logic [N_CLIENTS-1:0] ack;
  logic busy;
  logic [clog2(N_CLIENTS)-1:0] grant_id;
  logic tx_start;
  logic [DATA_BITS-1:0] d_in;
  logic tx_done_tick;
  logic timeout_err;
  modport master (
    input req, lock, w_data, tx_done_tick,
    output ack, busy, grant_id, tx_start, d_in, timeout_err
  );
  modport slave (
    output req, lock, w_data, tx_done_tick,
    input ack, busy, grant_id, tx_start, d_in, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_rr_pick: combinational rotate-priority encoder
//   in req (per client), ptr (highest-priority index); out any, winner
module uart_tx_rr_pick import uart_pkg::*; #(
  parameter int N_CLIENTS = 4
) (
  input  logic [N_CLIENTS-1:0]        req,
  input  logic [clog2(N_CLIENTS)-1:0] ptr,
  output logic                        any,
  output logic [clog2(N_CLIENTS)-1:0] winner
);
  localparam int IW = clog2(N_CLIENTS);
  logic [2*N_CLIENTS-1:0] dbl;
  // bit i of the low half is client (ptr+i) mod N, so the lowest set bit is the winner
  assign dbl = {req, req} >> ptr;
  assign any = |req;
  always_comb begin
    winner = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--)
      if (dbl[i]) winner = IW'((int'(ptr) + i) % N_CLIENTS);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with locked bursts and timeout
//   clk, reset (sync, active-high); b: uart_tx_arbiter_if.master bus
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_CLIENTS      = 4,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.master b
);
  localparam int IW = clog2(N_CLIENTS);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = clog2(TIMEOUT_CYCLES);
  logic [0:0] state;
  logic [IW-1:0] ptr, winner, next_ptr;
  logic [BW-1:0] burst;
  logic [TW-1:0] tcnt;
  logic [DATA_BITS-1:0] win_byte, own_byte;
  logic any, done, reload;
  uart_tx_rr_pick #(.N_CLIENTS(N_CLIENTS)) u_pick (
    .req(b.req), .ptr(ptr), .any(any), .winner(winner)
  );
  assign win_byte = b.w_data[int'(winner)*DATA_BITS +: DATA_BITS];
  assign own_byte = b.w_data[int'(b.grant_id)*DATA_BITS +: DATA_BITS];
  // a tick arriving while our own start pulse is still out belongs to an earlier byte
  assign done = b.tx_done_tick & ~b.tx_start;
  assign reload = b.lock[b.grant_id] & b.req[b.grant_id] & (burst < BW'(MAX_BURST));
  assign next_ptr = (b.grant_id == IW'(N_CLIENTS - 1)) ? '0 : b.grant_id + 1'b1;
  assign b.busy = state == ST_WAIT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      burst <= '0;
      tcnt <= '0;
      b.ack <= '0;
      b.tx_start <= 1'b0;
      b.timeout_err <= 1'b0;
      b.grant_id <= '0;
      b.d_in <= '1;
    end else begin
      b.ack <= '0;
      b.tx_start <= 1'b0;
      b.timeout_err <= 1'b0;
      if (state == ST_IDLE) begin
        if (any) begin
          state <= ST_WAIT;
          b.grant_id <= winner;
          b.d_in <= win_byte;
          b.tx_start <= 1'b1;
          b.ack <= N_CLIENTS'(1) << winner;
          burst <= BW'(1);
          tcnt <= '0;
        end
      end else if (done && reload) begin
        b.d_in <= own_byte;
        b.tx_start <= 1'b1;
        b.ack <= N_CLIENTS'(1) << b.grant_id;
        burst <= burst + 1'b1;
        tcnt <= '0;
      end else if (done || tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // done wins over a coincident terminal count
        b.timeout_err <= ~done;
        ptr <= next_ptr;
        state <= ST_IDLE;
      end else tcnt <= tcnt + 1'b1;
    end
  end
endmodule
